// File: rtl/stack_unit.sv
// stack_unit: LIFO stack with registered TOP/NEXT outputs, sticky overflow flag and synchronous CLEAR.
// Define STACK_UNDERFLOW_DETECT_EN to enable the sticky UNDERFLOW_OUT flag; otherwise it is tied low.
module stack_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            CTRL_STACK_OP,
    input  logic [DATA_WIDTH-1:0] STACK_IN,
    input  logic                  CLEAR,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic [DATA_WIDTH-1:0] TOP_DATA,
    output logic [DATA_WIDTH-1:0] NEXT_DATA,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  OVERFLOW_OUT,
    output logic                  UNDERFLOW_OUT
);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(STACK_DEPTH);

    typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPL} op_e;

    // stack_q[i] holds the entry at count i+1; the top two are mirrored in top_q/next_q
    logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] tos_q, tos_d, tos_m1, tos_m3;
    logic [DATA_WIDTH-1:0] top_q, top_d, next_q, next_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic                  empty, full, do_push, do_pop, do_repl;
    op_e                   op;

    assign op      = op_e'(CTRL_STACK_OP);
    assign empty   = tos_q == '0;
    assign full    = tos_q == DEPTH;
    assign tos_m1  = tos_q - ADDR_WIDTH'(1);
    assign tos_m3  = tos_q - ADDR_WIDTH'(3);
    assign do_push = !CLEAR && op == OP_PUSH && !full;
    assign do_pop  = !CLEAR && op == OP_POP && !empty;
    assign do_repl = !CLEAR && op == OP_REPL && !empty;
    assign wr_en   = do_push || do_repl;
    assign wr_idx  = do_push ? tos_q[IW-1:0] : tos_m1[IW-1:0];

    always_comb begin
        tos_d  = tos_q;
        top_d  = top_q;
        next_d = next_q;
        ovf_d  = ovf_q | (op == OP_PUSH && full);
        if (CLEAR) begin
            tos_d  = '0;
            top_d  = '0;
            next_d = '0;
            ovf_d  = 1'b0;
        end else if (do_push) begin
            tos_d  = tos_q + ADDR_WIDTH'(1);
            top_d  = STACK_IN;
            next_d = top_q;
        end else if (do_pop) begin
            tos_d  = tos_m1;
            top_d  = next_q;
            next_d = (tos_q >= ADDR_WIDTH'(3)) ? stack_q[tos_m3[IW-1:0]] : '0;
        end else if (do_repl) begin
            top_d  = STACK_IN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q  <= '0;
            top_q  <= '0;
            next_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tos_q  <= tos_d;
            top_q  <= top_d;
            next_q <= next_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) stack_q[wr_idx] <= STACK_IN;
    end

`ifdef STACK_UNDERFLOW_DETECT_EN
    logic udf_q, udf_d;

    always_comb begin
        udf_d = CLEAR ? 1'b0 : udf_q | ((op == OP_POP || op == OP_REPL) && empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) udf_q <= 1'b0;
        else        udf_q <= udf_d;
    end

    assign UNDERFLOW_OUT = udf_q;
`else
    assign UNDERFLOW_OUT = 1'b0;
`endif

    assign TOS_OUT      = tos_q;
    assign TOP_DATA     = top_q;
    assign NEXT_DATA    = next_q;
    assign EMPTY        = empty;
    assign FULL         = full;
    assign OVERFLOW_OUT = ovf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit at default parameters.
module tb_stack_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  CTRL_STACK_OP = 2'b00;
    logic [7:0]  STACK_IN = 8'h00;
    logic        CLEAR = 1'b0;
    logic [11:0] TOS_OUT;
    logic [7:0]  TOP_DATA, NEXT_DATA;
    logic        EMPTY, FULL, OVERFLOW_OUT, UNDERFLOW_OUT;
    int          errors = 0;
    int          checks = 0;

`ifdef STACK_UNDERFLOW_DETECT_EN
    localparam logic UDF_EXP = 1'b1;
`else
    localparam logic UDF_EXP = 1'b0;
`endif

    stack_unit dut (
        .clk(clk), .reset(reset), .CTRL_STACK_OP(CTRL_STACK_OP), .STACK_IN(STACK_IN),
        .CLEAR(CLEAR), .TOS_OUT(TOS_OUT), .TOP_DATA(TOP_DATA), .NEXT_DATA(NEXT_DATA),
        .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW_OUT(OVERFLOW_OUT), .UNDERFLOW_OUT(UNDERFLOW_OUT)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [1:0] op, input logic [7:0] d);
        CTRL_STACK_OP = op;
        STACK_IN = d;
        @(posedge clk);
        #1;
        CTRL_STACK_OP = 2'b00;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (TOS_OUT !== 12'd0) begin errors++; $display("FAIL reset_tos got=%0d exp=0", TOS_OUT); end
        checks++; if (TOP_DATA !== 8'h00 || NEXT_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got=%h/%h exp=00/00", TOP_DATA, NEXT_DATA); end
        checks++; if ({EMPTY, FULL, OVERFLOW_OUT, UNDERFLOW_OUT} !== 4'b1000) begin errors++; $display("FAIL reset_flags got=%b exp=1000", {EMPTY, FULL, OVERFLOW_OUT, UNDERFLOW_OUT}); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_push;
        do_op(2'b01, 8'h11);
        checks++; if (TOS_OUT !== 12'd1 || TOP_DATA !== 8'h11 || NEXT_DATA !== 8'h00 || EMPTY !== 1'b0) begin errors++; $display("FAIL push1 got tos=%0d top=%h next=%h empty=%b exp 1/11/00/0", TOS_OUT, TOP_DATA, NEXT_DATA, EMPTY); end
        do_op(2'b01, 8'h22);
        do_op(2'b01, 8'h33);
        checks++; if (TOS_OUT !== 12'd3 || TOP_DATA !== 8'h33 || NEXT_DATA !== 8'h22) begin errors++; $display("FAIL push3 got tos=%0d top=%h next=%h exp 3/33/22", TOS_OUT, TOP_DATA, NEXT_DATA); end
    endtask

    task automatic test_pop;
        do_op(2'b10, 8'h00);
        checks++; if (TOS_OUT !== 12'd2 || TOP_DATA !== 8'h22 || NEXT_DATA !== 8'h11) begin errors++; $display("FAIL pop1 got tos=%0d top=%h next=%h exp 2/22/11", TOS_OUT, TOP_DATA, NEXT_DATA); end
        do_op(2'b10, 8'h00);
        checks++; if (TOS_OUT !== 12'd1 || TOP_DATA !== 8'h11 || NEXT_DATA !== 8'h00) begin errors++; $display("FAIL pop2 got tos=%0d top=%h next=%h exp 1/11/00", TOS_OUT, TOP_DATA, NEXT_DATA); end
        do_op(2'b10, 8'h00);
        checks++; if (EMPTY !== 1'b1 || TOS_OUT !== 12'd0 || TOP_DATA !== 8'h00) begin errors++; $display("FAIL pop3 got empty=%b tos=%0d top=%h exp 1/0/00", EMPTY, TOS_OUT, TOP_DATA); end
    endtask

    task automatic test_underflow;
        checks++; if (UNDERFLOW_OUT !== 1'b0) begin errors++; $display("FAIL udf_pre got=%b exp=0", UNDERFLOW_OUT); end
        do_op(2'b10, 8'h00);
        checks++; if (UNDERFLOW_OUT !== UDF_EXP || TOS_OUT !== 12'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL udf_pop got udf=%b tos=%0d empty=%b exp %b/0/1", UNDERFLOW_OUT, TOS_OUT, EMPTY, UDF_EXP); end
        do_op(2'b11, 8'h5A);
        checks++; if (TOS_OUT !== 12'd0 || TOP_DATA !== 8'h00 || UNDERFLOW_OUT !== UDF_EXP) begin errors++; $display("FAIL udf_repl got tos=%0d top=%h udf=%b exp 0/00/%b", TOS_OUT, TOP_DATA, UNDERFLOW_OUT, UDF_EXP); end
    endtask

    task automatic test_replace;
        do_op(2'b01, 8'h07);
        do_op(2'b01, 8'h05);
        do_op(2'b11, 8'h0C);
        checks++; if (TOS_OUT !== 12'd2 || TOP_DATA !== 8'h0C || NEXT_DATA !== 8'h07) begin errors++; $display("FAIL repl got tos=%0d top=%h next=%h exp 2/0c/07", TOS_OUT, TOP_DATA, NEXT_DATA); end
        checks++; if (UNDERFLOW_OUT !== UDF_EXP) begin errors++; $display("FAIL udf_sticky got=%b exp=%b", UNDERFLOW_OUT, UDF_EXP); end
        do_op(2'b10, 8'h00);
        checks++; if (TOS_OUT !== 12'd1 || TOP_DATA !== 8'h07 || NEXT_DATA !== 8'h00) begin errors++; $display("FAIL repl_pop got tos=%0d top=%h next=%h exp 1/07/00", TOS_OUT, TOP_DATA, NEXT_DATA); end
        do_op(2'b10, 8'h00);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 64; i++) begin
            logic [7:0] v;
            v = 8'(i);
            do_op(2'b01, v);
        end
        checks++; if (FULL !== 1'b1 || TOS_OUT !== 12'd64 || TOP_DATA !== 8'h40 || NEXT_DATA !== 8'h3F || OVERFLOW_OUT !== 1'b0) begin errors++; $display("FAIL fill got full=%b tos=%0d top=%h next=%h ovf=%b exp 1/64/40/3f/0", FULL, TOS_OUT, TOP_DATA, NEXT_DATA, OVERFLOW_OUT); end
        do_op(2'b01, 8'hAA);
        checks++; if (FULL !== 1'b1 || TOS_OUT !== 12'd64 || TOP_DATA !== 8'h40 || NEXT_DATA !== 8'h3F || OVERFLOW_OUT !== 1'b1) begin errors++; $display("FAIL ovf got full=%b tos=%0d top=%h next=%h ovf=%b exp 1/64/40/3f/1", FULL, TOS_OUT, TOP_DATA, NEXT_DATA, OVERFLOW_OUT); end
        do_op(2'b10, 8'h00);
        checks++; if (TOS_OUT !== 12'd63 || TOP_DATA !== 8'h3F || NEXT_DATA !== 8'h3E || OVERFLOW_OUT !== 1'b1 || FULL !== 1'b0) begin errors++; $display("FAIL ovf_pop got tos=%0d top=%h next=%h ovf=%b full=%b exp 63/3f/3e/1/0", TOS_OUT, TOP_DATA, NEXT_DATA, OVERFLOW_OUT, FULL); end
        for (int i = 0; i < 58; i++) do_op(2'b10, 8'h00);
        checks++; if (TOS_OUT !== 12'd5 || TOP_DATA !== 8'h05 || NEXT_DATA !== 8'h04 || OVERFLOW_OUT !== 1'b1) begin errors++; $display("FAIL drain got tos=%0d top=%h next=%h ovf=%b exp 5/05/04/1", TOS_OUT, TOP_DATA, NEXT_DATA, OVERFLOW_OUT); end
    endtask

    task automatic test_clear;
        CLEAR = 1'b1;
        do_op(2'b01, 8'h44);
        CLEAR = 1'b0;
        checks++; if (TOS_OUT !== 12'd0 || EMPTY !== 1'b1 || TOP_DATA !== 8'h00 || NEXT_DATA !== 8'h00) begin errors++; $display("FAIL clear got tos=%0d empty=%b top=%h next=%h exp 0/1/00/00", TOS_OUT, EMPTY, TOP_DATA, NEXT_DATA); end
        checks++; if (OVERFLOW_OUT !== 1'b0 || UNDERFLOW_OUT !== 1'b0) begin errors++; $display("FAIL clear_flags got ovf=%b udf=%b exp 0/0", OVERFLOW_OUT, UNDERFLOW_OUT); end
    endtask

    task automatic test_reset_mid_op;
        do_op(2'b01, 8'h21);
        do_op(2'b01, 8'h43);
        checks++; if (TOS_OUT !== 12'd2 || TOP_DATA !== 8'h43 || NEXT_DATA !== 8'h21) begin errors++; $display("FAIL pre_rst got tos=%0d top=%h next=%h exp 2/43/21", TOS_OUT, TOP_DATA, NEXT_DATA); end
        CTRL_STACK_OP = 2'b01;
        STACK_IN = 8'h99;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (TOS_OUT !== 12'd0 || TOP_DATA !== 8'h00 || NEXT_DATA !== 8'h00 || {EMPTY, FULL, OVERFLOW_OUT, UNDERFLOW_OUT} !== 4'b1000) begin errors++; $display("FAIL async_rst got tos=%0d top=%h next=%h flags=%b exp 0/00/00/1000", TOS_OUT, TOP_DATA, NEXT_DATA, {EMPTY, FULL, OVERFLOW_OUT, UNDERFLOW_OUT}); end
        @(posedge clk);
        #1;
        checks++; if (TOS_OUT !== 12'd0 || TOP_DATA !== 8'h00) begin errors++; $display("FAIL rst_hold got tos=%0d top=%h exp 0/00", TOS_OUT, TOP_DATA); end
        CTRL_STACK_OP = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        do_op(2'b01, 8'h55);
        checks++; if (TOS_OUT !== 12'd1 || TOP_DATA !== 8'h55 || NEXT_DATA !== 8'h00) begin errors++; $display("FAIL post_rst got tos=%0d top=%h next=%h exp 1/55/00", TOS_OUT, TOP_DATA, NEXT_DATA); end
    endtask

    initial begin
        test_reset;
        test_push;
        test_pop;
        test_underflow;
        test_replace;
        test_overflow;
        test_clear;
        test_reset_mid_op;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: STACK_UNIT

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one stack entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of the TOS pointer.
REQ-003 SHALL have parameter STACK_DEPTH, default 64, number of entries, 2 <= STACK_DEPTH <= 2**ADDR_WIDTH-1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port CTRL_STACK_OP  input  2  operation code: 00 nop, 01 push, 10 pop, 11 replace (pop then push in one cycle).
REQ-007 SHALL have port STACK_IN  input  DATA_WIDTH  data for push and replace; driven from the control unit STACK_OUT.
REQ-008 SHALL have port CLEAR  input  1  synchronous flush of the whole stack.
REQ-009 SHALL have port TOS_OUT  output  ADDR_WIDTH  current entry count; feeds the control unit TOS_IN.
REQ-010 SHALL have port TOP_DATA  output  DATA_WIDTH  top entry, registered.
REQ-011 SHALL have port NEXT_DATA  output  DATA_WIDTH  second entry, registered; feeds the second ALU operand.
REQ-012 SHALL have port EMPTY  output  1  high when TOS_OUT == 0.
REQ-013 SHALL have port FULL  output  1  high when TOS_OUT == STACK_DEPTH.
REQ-014 SHALL have port OVERFLOW_OUT  output  1  sticky error flag for a push on a full stack; feeds the control unit OVERFLOW_IN.
REQ-015 SHALL have port UNDERFLOW_OUT  output  1  sticky error flag for a pop or replace on an empty stack.

Function
REQ-016 SHALL store entries in an internal array plus TOP and NEXT holding registers; TOP_DATA and NEXT_DATA SHALL come from those registers, with no combinational path from inputs.
REQ-017 SHALL complete every operation in one cycle: an op sampled at edge N is visible on all outputs after edge N.
REQ-018 SHALL, on push when not FULL, increment TOS_OUT, set TOP_DATA to STACK_IN, and set NEXT_DATA to the old TOP_DATA.
REQ-019 SHALL, on pop when not EMPTY, decrement TOS_OUT, set TOP_DATA to the old NEXT_DATA, and set NEXT_DATA to the entry at depth 3, or 0 if that entry does not exist.
REQ-020 SHALL, on replace when not EMPTY, keep TOS_OUT unchanged, set TOP_DATA to STACK_IN, and leave NEXT_DATA unchanged.
REQ-021 SHALL, on push when FULL, leave all contents and TOS_OUT unchanged and set OVERFLOW_OUT.
REQ-022 SHALL, on pop or replace when EMPTY, leave all contents and TOS_OUT unchanged; UNDERFLOW_OUT behaviour is given in REQ-031/032.
REQ-023 SHALL drive TOP_DATA = 0 when EMPTY, and NEXT_DATA = 0 when TOS_OUT < 2.
REQ-024 SHALL give CLEAR priority over CTRL_STACK_OP: TOS_OUT, TOP_DATA and NEXT_DATA go to 0 and both error flags clear at the next edge.
REQ-025 SHALL hold OVERFLOW_OUT and UNDERFLOW_OUT until CLEAR or reset.
REQ-026 SHALL never let TOS_OUT wrap: it is bounded to 0..STACK_DEPTH.

Reset
REQ-027 SHALL, while reset is low, force TOS_OUT=0, TOP_DATA=0, NEXT_DATA=0, EMPTY=1, FULL=0, OVERFLOW_OUT=0 and UNDERFLOW_OUT=0, asynchronously.
REQ-028 SHALL leave array contents undefined after reset; they are never observable because the stack is empty.
REQ-029 SHALL, when reset is asserted mid-operation, discard the in-flight op; the first op after reset release acts on an empty stack.

Configuration
REQ-030 SHALL use macro STACK_UNDERFLOW_DETECT_EN.
REQ-031 SHALL, when STACK_UNDERFLOW_DETECT_EN is defined, set UNDERFLOW_OUT sticky per REQ-022 and REQ-025.
REQ-032 SHALL, when STACK_UNDERFLOW_DETECT_EN is undefined, tie UNDERFLOW_OUT to 0; pop or replace on an empty stack is still ignored silently.

Verification
REQ-033 SHALL cover: reset, then push 0x11, push 0x22, push 0x33 -> TOS_OUT=3, TOP_DATA=0x33, NEXT_DATA=0x22.
REQ-034 SHALL cover: from REQ-033, pop, pop -> TOS_OUT=1, TOP_DATA=0x11, NEXT_DATA=0; a further pop -> EMPTY=1, TOP_DATA=0.
REQ-035 SHALL cover: stack holding 0x05 over 0x07, replace with 0x0C -> TOS_OUT=2, TOP_DATA=0x0C, NEXT_DATA=0x07.
REQ-036 SHALL cover: fill to STACK_DEPTH=64, then push 0xAA -> FULL=1, TOS_OUT=64, TOP_DATA unchanged, OVERFLOW_OUT=1 sticky through a following pop.
REQ-037 SHALL cover: empty stack, pop -> UNDERFLOW_OUT=1 with the macro defined, 0 without; TOS_OUT=0 in both cases.
REQ-038 SHALL cover: CLEAR=1 together with push 0x44 on a 5-deep stack -> TOS_OUT=0, EMPTY=1, flags cleared; reset low mid-push -> all outputs 0 immediately, without waiting for a clock edge.
